// File: rtl/router_fifo_if.sv
// router_fifo_if: FIFO bus; master drives write_enb/read_enb/lfd_state/data_in, slave returns data_out/full/empty/busy
interface router_fifo_if #(parameter int WIDTH = 8);
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             busy;
  modport master(output write_enb, read_enb, lfd_state, data_in, input data_out, full, empty, busy);
  modport slave(input write_enb, read_enb, lfd_state, data_in, output data_out, full, empty, busy);
endinterface

// File: rtl/router_fifo.sv
// router_fifo: header-tagged per-destination byte FIFO with packet-length tracking and soft flush; ports clock/reset/soft_reset plus bus (write_enb, read_enb, lfd_state, data_in in; data_out, full, empty, busy out)
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           soft_reset,
  router_fifo_if.slave   bus
);
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [6:0]       r_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;
  logic             w_clr;
  logic [WIDTH:0]   w_rd_word;
  logic [6:0]       w_len;
  assign w_empty   = r_wr_ptr == r_rd_ptr;
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_clr     = reset || soft_reset;
  assign w_wr      = bus.write_enb && !w_full && !w_clr;
  assign w_rd      = bus.read_enb && !w_empty && !w_clr;
  assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];
  assign w_len     = 7'(w_rd_word[WIDTH-1:2]) + 7'd1;
  always_ff @(posedge clock)
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= w_rd_word[WIDTH-1:0];
        r_cnt      <= w_rd_word[WIDTH] ? w_len : (r_cnt != 7'd0 ? r_cnt - 7'd1 : 7'd0);
      end
    end
  end
  assign bus.data_out = r_data_out;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.busy     = r_cnt != 7'd0;
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed plus randomized checks of router_fifo against a queue-based model
module tb_router_fifo;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic soft_reset = 1'b0;
  int total = 0;
  int bad = 0;
  logic [8:0] q[$];
  int m_cnt = 0;
  logic [7:0] m_dout = 8'h00;
  router_fifo_if #(.WIDTH(8)) bus();
  router_fifo #(.DEPTH(16), .WIDTH(8), .AW(4)) dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .bus(bus.slave)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_model(input string tag);
    chk({tag, "_dout"}, bus.data_out, m_dout);
    chk({tag, "_full"}, {7'b0, bus.full}, {7'b0, q.size() == 16});
    chk({tag, "_empty"}, {7'b0, bus.empty}, {7'b0, q.size() == 0});
    chk({tag, "_busy"}, {7'b0, bus.busy}, {7'b0, m_cnt != 0});
  endtask
  task automatic step(input logic we, input logic re, input logic lfd, input logic [7:0] din, input logic sr, input string tag);
    bit rd, wr;
    logic [8:0] w;
    bus.write_enb = we;
    bus.read_enb = re;
    bus.lfd_state = lfd;
    bus.data_in = din;
    soft_reset = sr;
    @(posedge clock);
    if (sr) begin
      q.delete();
      m_cnt = 0;
      m_dout = 8'h00;
    end else begin
      rd = re && q.size() > 0;
      wr = we && q.size() < 16;
      if (rd) begin
        w = q.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_cnt = int'(w[7:2]) + 1;
        else if (m_cnt > 0) m_cnt--;
      end
      if (wr) q.push_back({lfd, din});
    end
    #1;
    chk_model(tag);
    bus.write_enb = 1'b0;
    bus.read_enb = 1'b0;
    bus.lfd_state = 1'b0;
    soft_reset = 1'b0;
  endtask
  task automatic wr(input logic lfd, input logic [7:0] d);
    step(1'b1, 1'b0, lfd, d, 1'b0, "wr");
  endtask
  task automatic rd();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "rd");
  endtask
  initial begin
    logic [7:0] pkt[5];
    bus.write_enb = 1'b0;
    bus.read_enb = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_dout", bus.data_out, 8'h00);
    chk("rst_full", {7'b0, bus.full}, 8'h00);
    chk("rst_empty", {7'b0, bus.empty}, 8'h01);
    chk("rst_busy", {7'b0, bus.busy}, 8'h00);
    pkt = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'hAF};
    wr(1'b1, 8'h0D);
    for (int i = 1; i < 5; i++) wr(1'b0, pkt[i]);
    for (int i = 0; i < 5; i++) begin
      rd();
      chk("pkt_data", bus.data_out, pkt[i]);
      chk("pkt_busy", {7'b0, bus.busy}, {7'b0, i != 4});
    end
    chk("pkt_empty", {7'b0, bus.empty}, 8'h01);
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(i));
    chk("fill_full", {7'b0, bus.full}, 8'h01);
    wr(1'b0, 8'hFF);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("fill_data", bus.data_out, 8'(i));
    end
    chk("fill_empty", {7'b0, bus.empty}, 8'h01);
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h20 + i));
    step(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, "full_rw");
    chk("full_rw_data", bus.data_out, 8'h20);
    chk("full_rw_full", {7'b0, bus.full}, 8'h00);
    wr(1'b0, 8'h55);
    for (int i = 0; i < 16; i++) rd();
    chk("full_rw_last", bus.data_out, 8'h55);
    chk("full_rw_empty", {7'b0, bus.empty}, 8'h01);
    step(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, "empty_rw");
    chk("empty_rw_data", bus.data_out, 8'h55);
    chk("empty_rw_empty", {7'b0, bus.empty}, 8'h00);
    rd();
    chk("empty_rw_read", bus.data_out, 8'h3C);
    for (int i = 0; i < 10; i++) wr(1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 8; i++) rd();
    for (int i = 0; i < 12; i++) wr(1'b0, 8'(8'h60 + i));
    chk("wrap_full", {7'b0, bus.full}, 8'h00);
    rd();
    chk("wrap_first", bus.data_out, 8'h48);
    rd();
    for (int i = 0; i < 12; i++) begin
      rd();
      chk("wrap_data", bus.data_out, 8'(8'h60 + i));
    end
    chk("wrap_empty", {7'b0, bus.empty}, 8'h01);
    wr(1'b1, 8'h11);
    for (int i = 0; i < 5; i++) wr(1'b0, 8'(8'h70 + i));
    rd();
    chk("mid_hdr_busy", {7'b0, bus.busy}, 8'h01);
    rd();
    rd();
    step(1'b1, 1'b0, 1'b0, 8'h77, 1'b1, "srst");
    chk("srst_busy", {7'b0, bus.busy}, 8'h00);
    chk("srst_empty", {7'b0, bus.empty}, 8'h01);
    chk("srst_dout", bus.data_out, 8'h00);
    rd();
    chk("srst_nostore", {7'b0, bus.empty}, 8'h01);
    for (int p = 0; p < 6; p++) begin
      int wb = (p % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 100; i++)
        step(1'($urandom % 100 < wb), 1'($urandom % 100 < 100 - wb + 10), 1'($urandom % 6 == 0),
             8'($urandom), 1'($urandom % 60 == 0), "rand");
    end
    for (int i = 0; i < 6; i++) wr(1'($urandom % 2), 8'($urandom));
    reset = 1'b1;
    @(posedge clock);
    q.delete();
    m_cnt = 0;
    m_dout = 8'h00;
    #1;
    reset = 1'b0;
    chk("hrst_empty", {7'b0, bus.empty}, 8'h01);
    chk("hrst_dout", bus.data_out, 8'h00);
    chk_model("hrst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
